// File: rtl/swire_pkg.sv
// Shared types and default timing for the S-Wire pulse generator that programs
// the AMOLED PMIC ELVDD/ELVSS levels.
package swire_pkg;

    localparam int CNT_W          = 6;
    localparam int TMR_W          = 16;
    localparam int T_LOW_DEF      = 38;
    localparam int T_HIGH_DEF     = 38;
    localparam int T_GAP_DEF      = 20000;
    localparam int MAX_PULSES_DEF = 48;

    typedef enum logic [3:0] {
        OFF,
        IDLE,
        LOAD,
        A_LOW,
        A_HIGH,
        GAP_A,
        B_LOW,
        B_HIGH,
        GAP_B
    } swire_state_e;

    // The PMIC only understands MAX_PULSES steps, so larger fields saturate.
    function automatic logic [CNT_W-1:0] clamp_count(
        input logic [CNT_W-1:0] field,
        input logic [CNT_W-1:0] max_cnt
    );
        return (field > max_cnt) ? max_cnt : field;
    endfunction

endpackage

// File: rtl/swire_sync_stable.sv
// Brings a quasi-static register value into the 38.4 MHz domain and accepts it
// only once two consecutive synchronised samples agree.
module swire_sync_stable
    import swire_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [IN_W-1:0]  data_i,
    output logic [OUT_W-1:0] data_o
);

    logic [IN_W-1:0]  meta_q;
    logic [IN_W-1:0]  sync_q;
    logic [IN_W-1:0]  prev_q;
    logic [OUT_W-1:0] stable_q;

    // The full word takes part in the comparison so a half-written value in any
    // bit holds off acceptance, even though only the low field is forwarded.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q   <= '0;
            sync_q   <= '0;
            prev_q   <= '0;
            stable_q <= '0;
        end else begin
            meta_q <= data_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
            if (sync_q == prev_q) begin
                stable_q <= sync_q[OUT_W-1:0];
            end
        end
    end

    assign data_o = stable_q;

endmodule

// File: rtl/swire_pulse_gen.sv
// Turns the sniffed B1/B5 panel-power values into two S-Wire pulse bursts; the
// PMIC counts falling edges in each burst and latches during the closing gap.
module swire_pulse_gen
    import swire_pkg::*;
#(
    parameter int T_LOW      = T_LOW_DEF,
    parameter int T_HIGH     = T_HIGH_DEF,
    parameter int T_GAP      = T_GAP_DEF,
    parameter int MAX_PULSES = MAX_PULSES_DEF
) (
    input  logic        i_clk_38m,
    input  logic        i_reset,
    input  logic        i_swire_start,
    input  logic [15:0] i_b1_data,
    input  logic [15:0] i_b5_data,
    output logic        o_swire,
    output logic        o_busy,
    output logic        o_done
);

    localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_PULSES);
    localparam logic [TMR_W-1:0] LOW_LOAD  = TMR_W'(T_LOW - 1);
    localparam logic [TMR_W-1:0] HIGH_LOAD = TMR_W'(T_HIGH - 1);
    localparam logic [TMR_W-1:0] GAP_LOAD  = TMR_W'(T_GAP - 1);

    swire_state_e     state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] sent_a_q, sent_a_d;
    logic [CNT_W-1:0] sent_b_q, sent_b_d;
    logic             pending_q, pending_d;
    logic             swire_q, swire_d;
    logic             done_q, done_d;

    logic [CNT_W-1:0] field_a, field_b;
    logic [CNT_W-1:0] cnt_a, cnt_b;
    logic             phase_end;

    swire_sync_stable #(.IN_W(16), .OUT_W(CNT_W)) u_sync_b1 (
        .clk_i  (i_clk_38m),
        .rst_i  (i_reset),
        .data_i (i_b1_data),
        .data_o (field_a)
    );

    swire_sync_stable #(.IN_W(16), .OUT_W(CNT_W)) u_sync_b5 (
        .clk_i  (i_clk_38m),
        .rst_i  (i_reset),
        .data_i (i_b5_data),
        .data_o (field_b)
    );

    assign cnt_a     = clamp_count(field_a, MAX_CNT);
    assign cnt_b     = clamp_count(field_b, MAX_CNT);
    assign phase_end = (timer_q == '0);

    always_ff @(posedge i_clk_38m or posedge i_reset) begin
        if (i_reset) begin
            state_q <= OFF;
        end else begin
            state_q <= state_d;
        end
    end

    // Dropping i_swire_start overrides every state so the pin goes low at once.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            OFF:    if (i_swire_start) state_d = IDLE;
            IDLE:   if (pending_q) state_d = LOAD;
            LOAD:   state_d = (cnt_a != '0) ? A_LOW : GAP_A;
            A_LOW:  if (phase_end) state_d = A_HIGH;
            A_HIGH: if (phase_end) state_d = (rem_q == CNT_W'(1)) ? GAP_A : A_LOW;
            GAP_A:  if (phase_end) state_d = (sent_b_q != '0) ? B_LOW : GAP_B;
            B_LOW:  if (phase_end) state_d = B_HIGH;
            B_HIGH: if (phase_end) state_d = (rem_q == CNT_W'(1)) ? GAP_B : B_LOW;
            GAP_B:  if (phase_end) state_d = IDLE;
            default: state_d = OFF;
        endcase
        if (!i_swire_start) begin
            state_d = OFF;
        end
    end

    // Pin level and done strobe follow the next state so they land in the same
    // clock as the state they describe, without decode glitches on the pin.
    always_comb begin
        swire_d = !(state_d inside {OFF, A_LOW, B_LOW});
        done_d  = (state_q == GAP_B) && (state_d == IDLE);
        o_busy  = !(state_q inside {OFF, IDLE});
    end

    // sent_* double as the latched counts of the burst in flight.
    always_comb begin
        pending_d = pending_q;
        sent_a_d  = sent_a_q;
        sent_b_d  = sent_b_q;
        rem_d     = rem_q;
        timer_d   = timer_q;

        if (state_d == OFF) begin
            pending_d = 1'b0;
        end else if (state_q == LOAD) begin
            pending_d = 1'b0;
            sent_a_d  = cnt_a;
            sent_b_d  = cnt_b;
        end else if (state_q == OFF) begin
            pending_d = 1'b1;
        end else if ((cnt_a != sent_a_q) || (cnt_b != sent_b_q)) begin
            pending_d = 1'b1;
        end

        if (state_q == LOAD) begin
            rem_d = cnt_a;
        end else if ((state_q == GAP_A) && (state_d == B_LOW)) begin
            rem_d = sent_b_q;
        end else if ((state_q inside {A_HIGH, B_HIGH}) && phase_end) begin
            rem_d = rem_q - CNT_W'(1);
        end

        if (state_d != state_q) begin
            unique case (state_d)
                A_LOW, B_LOW:   timer_d = LOW_LOAD;
                A_HIGH, B_HIGH: timer_d = HIGH_LOAD;
                GAP_A, GAP_B:   timer_d = GAP_LOAD;
                default:        timer_d = '0;
            endcase
        end else if (!phase_end) begin
            timer_d = timer_q - TMR_W'(1);
        end
    end

    always_ff @(posedge i_clk_38m or posedge i_reset) begin
        if (i_reset) begin
            timer_q   <= '0;
            rem_q     <= '0;
            sent_a_q  <= '0;
            sent_b_q  <= '0;
            pending_q <= 1'b0;
            swire_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            timer_q   <= timer_d;
            rem_q     <= rem_d;
            sent_a_q  <= sent_a_d;
            sent_b_q  <= sent_b_d;
            pending_q <= pending_d;
            swire_q   <= swire_d;
            done_q    <= done_d;
        end
    end

    assign o_swire = swire_q;
    assign o_done  = done_q;

endmodule

// File: tb/tb_swire_pulse_gen.sv
// Scoreboard bench for swire_pulse_gen: expected bursts are queued as stimulus
// is applied and a pin monitor decodes each finished update and compares it.
module tb_swire_pulse_gen;

    localparam int TL  = 6;
    localparam int TH  = 4;
    localparam int TG  = 50;
    localparam int MAXP = 48;

    typedef struct {
        int na;
        int nb;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] b1;
    logic [15:0] b5;
    logic        swire;
    logic        busy;
    logic        done;

    int   compared   = 0;
    int   mismatched = 0;
    int   doneSeen   = 0;
    exp_t expQ[$];
    exp_t cur;

    int nA, nB, lowRun, highRun, busyLen, badW;
    bit inB;

    swire_pulse_gen #(
        .T_LOW      (TL),
        .T_HIGH     (TH),
        .T_GAP      (TG),
        .MAX_PULSES (MAXP)
    ) dut (
        .i_clk_38m     (clk),
        .i_reset       (rst),
        .i_swire_start (start),
        .i_b1_data     (b1),
        .i_b5_data     (b5),
        .o_swire       (swire),
        .o_busy        (busy),
        .o_done        (done)
    );

    always #5 clk = ~clk;

    // Reference rule: low CNT_W bits of the register, saturated at MAXP.
    function automatic int modelCount(input logic [15:0] v);
        int f;
        f = int'(v[5:0]);
        return (f > MAXP) ? MAXP : f;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic s);
        b1    = a;
        b5    = b;
        start = s;
    endtask

    task automatic expectUpdate(input int a, input int b);
        exp_t e;
        e.na = a;
        e.nb = b;
        expQ.push_back(e);
    endtask

    task automatic waitDones(input int n, input int budget);
        int target;
        int k;
        target = doneSeen + n;
        k = 0;
        while (doneSeen < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        checkOutput("done_count", doneSeen, target);
    endtask

    task automatic waitBusy(input int budget);
        int k;
        k = 0;
        while (!busy && k < budget) begin
            @(negedge clk);
            k++;
        end
        checkOutput("busy_rise", int'(busy), 1);
    endtask

    task automatic clearAccum();
        nA = 0; nB = 0; lowRun = 0; highRun = 0; busyLen = 0; badW = 0; inB = 0;
    endtask

    // Pin monitor: a high run of at least TG while busy closes burst A.
    always @(negedge clk) begin
        if (rst) begin
            clearAccum();
        end else begin
            if (busy) begin
                busyLen++;
                if (!swire) begin
                    lowRun++;
                end else begin
                    if (lowRun > 0) begin
                        if (inB) nB++; else nA++;
                        if (lowRun != TL) badW++;
                        lowRun  = 0;
                        highRun = 0;
                    end
                    highRun++;
                    if (!inB && highRun >= TG) inB = 1;
                end
            end
            if (done) begin
                doneSeen++;
                checkOutput("exp_queue_nonempty", int'(expQ.size() > 0), 1);
                if (expQ.size() > 0) begin
                    cur = expQ.pop_front();
                    checkOutput("burst_a_pulses", nA, cur.na);
                    checkOutput("burst_b_pulses", nB, cur.nb);
                    checkOutput("low_width_errors", badW, 0);
                    checkOutput("update_length", busyLen, 1 + (cur.na + cur.nb) * (TL + TH) + 2 * TG);
                end
                clearAccum();
            end else if (!busy) begin
                clearAccum();
            end
        end
    end

    initial begin
        int sentA;
        int sentB;
        int busySeen;
        int doneMark;
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] ra;
        logic [15:0] rb;

        clearAccum();
        rst = 1'b1;
        applyStimulus(16'h0005, 16'h0003, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("reset_swire", int'(swire), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_done", int'(done), 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("off_swire_low", int'(swire), 0);

        $display("[TB] first update 5/3");
        expectUpdate(5, 3);
        start = 1'b1;
        @(negedge clk);
        checkOutput("idle_swire_high", int'(swire), 1);
        checkOutput("idle_not_busy", int'(busy), 0);
        @(negedge clk);
        checkOutput("load_busy", int'(busy), 1);
        checkOutput("load_swire_high", int'(swire), 1);
        @(negedge clk);
        checkOutput("first_fall_latency", int'(swire), 0);
        waitDones(1, 3000);

        $display("[TB] data change during burst A");
        start = 1'b0;
        @(negedge clk);
        expectUpdate(5, 3);
        start = 1'b1;
        waitBusy(50);
        repeat (3) @(negedge clk);
        b1 = 16'h000A;
        expectUpdate(10, 3);
        waitDones(2, 6000);

        $display("[TB] clamp and zero field");
        b1 = 16'h003F;
        expectUpdate(48, 3);
        waitDones(1, 3000);
        b1 = 16'h0040;
        expectUpdate(0, 3);
        waitDones(1, 3000);

        $display("[TB] start dropped in B_LOW");
        b1 = 16'h0005;
        waitBusy(50);
        repeat (1 + 5 * (TL + TH) + TG + 2) @(negedge clk);
        checkOutput("in_b_low", int'(swire), 0);
        start = 1'b0;
        @(negedge clk);
        checkOutput("abort_swire", int'(swire), 0);
        checkOutput("abort_busy", int'(busy), 0);
        repeat (5) @(negedge clk);
        expectUpdate(5, 3);
        start = 1'b1;
        waitDones(1, 3000);

        $display("[TB] toggling B5 then settling");
        x = 16'($urandom);
        y = x ^ 16'(1 + $urandom_range(0, 65534));
        busySeen = 0;
        for (int i = 0; i < 10; i++) begin
            b5 = (i % 2 == 0) ? x : y;
            @(negedge clk);
            if (busy) busySeen++;
        end
        b5 = 16'h0004;
        repeat (3) begin
            @(negedge clk);
            if (busy) busySeen++;
        end
        checkOutput("no_update_while_toggling", busySeen, 0);
        expectUpdate(5, 4);
        waitDones(1, 3000);
        doneMark = doneSeen;
        repeat (300) @(negedge clk);
        checkOutput("no_extra_done", doneSeen, doneMark);

        $display("[TB] reset during A_HIGH");
        b1 = 16'h0007;
        waitBusy(50);
        repeat (1 + TL + 2) @(negedge clk);
        checkOutput("in_a_high", int'(swire), 1);
        #2;
        rst   = 1'b1;
        start = 1'b0;
        #1;
        checkOutput("async_reset_swire", int'(swire), 0);
        checkOutput("async_reset_busy", int'(busy), 0);
        checkOutput("async_reset_done", int'(done), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        expectUpdate(7, 4);
        start = 1'b1;
        waitDones(1, 3000);

        $display("[TB] both counts zero");
        b1 = 16'h0000;
        b5 = 16'h0000;
        expectUpdate(0, 0);
        waitDones(1, 3000);

        $display("[TB] random register values");
        sentA = 0;
        sentB = 0;
        for (int r = 0; r < 6; r++) begin
            do begin
                ra = 16'($urandom);
                rb = 16'($urandom);
            end while (modelCount(ra) == sentA && modelCount(rb) == sentB);
            applyStimulus(ra, rb, 1'b1);
            expectUpdate(modelCount(ra), modelCount(rb));
            sentA = modelCount(ra);
            sentB = modelCount(rb);
            waitDones(1, 3000);
        end

        repeat (20) @(negedge clk);
        checkOutput("exp_queue_empty", expQ.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/swire_pulse_gen.md
Name: swire_pulse_gen

Overview:
- Downstream stage of the DSI register sniffer.
- Converts captured B1/B5 panel-power register values into an S-Wire pulse train for the AMOLED PMIC, which counts falling edges to set ELVDD/ELVSS.
- Runs in the 38.4 MHz domain, behind the power-up start-delay counter.
- Drives the board S-Wire pin.

Parameters:
- T_LOW, 38: low time of each pulse, in clocks (≈1 µs).
- T_HIGH, 38: high time between pulses, in clocks.
- T_GAP, 20000: high idle time closing each burst (PMIC latch time), in clocks.
- CNT_W, 6: width of the pulse-count field taken from each register.
- MAX_PULSES, 48: counts above this are clamped to this value.

Ports:
- i_clk_38m in 1: 38.4 MHz clock.
- i_reset in 1: asynchronous reset, active-high.
- i_swire_start in 1: level; high = PMIC enabled, low = pin forced low.
- i_b1_data in 16: B1 register value; burst-A count = [CNT_W-1:0].
- i_b5_data in 16: B5 register value; burst-B count = [CNT_W-1:0].
- o_swire out 1: S-Wire pin drive.
- o_busy out 1: high whenever state is not OFF or IDLE.
- o_done out 1: one-clock pulse after a full update (both bursts plus their gaps).

Behaviour:
- Reset values: o_swire=0, o_busy=0, o_done=0, state=OFF, sent_a=sent_b=0, pending=0.
- Input sync: i_b1_data/i_b5_data are quasi-static (different clock domain). Double-register them; a value is accepted only after 2 consecutive equal samples.
- Count rule: cnt = min(field, MAX_PULSES), unsigned, CNT_W bits.
- pending is set when:
  - the accepted cnt_a/cnt_b differs from sent_a/sent_b, or
  - on the first entry to IDLE after OFF.
- States:
  - OFF: o_swire=0. Go to IDLE when i_swire_start=1.
  - IDLE: o_swire=1. If pending, go to LOAD.
  - LOAD (1 clk): latch cur_a/cur_b from accepted counts, clear pending, sent_a<=cur_a, sent_b<=cur_b. Go to A_LOW if cur_a≠0, else GAP_A.
  - A_LOW: o_swire=0 for T_LOW clks, then A_HIGH.
  - A_HIGH: o_swire=1 for T_HIGH clks; decrement remaining count. If remaining=0 go to GAP_A, else A_LOW.
  - GAP_A: o_swire=1 for T_GAP clks, then B_LOW if cur_b≠0, else GAP_B.
  - B_LOW / B_HIGH: same as A_LOW / A_HIGH using cur_b; exit to GAP_B.
  - GAP_B: o_swire=1 for T_GAP clks, then o_done=1 for 1 clk and go to IDLE.
- Phase timing: counter of 16 bits, loaded with T-1 on phase entry. Phase ends at 0, so each phase lasts exactly T clks.
- o_swire is registered: the first falling edge appears exactly 2 clks after pending is seen in IDLE.
- Data change mid-burst: the current burst completes with the latched counts; pending is re-raised; the next update starts from IDLE right after GAP_B.
- Both counts zero: still traverse GAP_A+GAP_B (2·T_GAP high), no low pulses, o_done fires.
- i_swire_start falling in any state: next clk state=OFF, o_swire=0, pending cleared, sent_* kept. The next rise re-sends the current counts (first-entry rule).
- i_reset mid-burst: immediate return to reset values; no partial-pulse completion.
- Pulse count on the pin equals cur_a (resp. cur_b) exactly; no extra edges at state transitions.

Decomposition:
- Package swire_pkg holds:
  - state enum: OFF, IDLE, LOAD, A_LOW, A_HIGH, GAP_A, B_LOW, B_HIGH, GAP_B;
  - default timing constants;
  - CNT_W.
- One sub-module, swire_sync_stable: 2-flop sync plus equal-sample filter per 16-bit input, instantiated twice.

Test Plan:
- Reset, then i_swire_start=1 with b1=0x0005, b5=0x0003 -> o_swire low→high, then 5 low pulses of 38 clks each, 20000-clk gap, 3 pulses, gap, single o_done.
- During burst A change b1 to 0x000A -> current burst sends 5/3; a second update then sends 10/3; two o_done pulses total.
- b1=0x003F (63) -> exactly 48 pulses (clamp); b1=0x0040 -> field 0 -> no A pulses, 20000+T_GAP high, B burst only.
- Deassert i_swire_start in B_LOW -> o_swire=0 next clk, o_busy=0. Reassert -> full 5/3 resend.
- b5 toggling every 1 clk for 10 clks, then settling to 0x0004 -> no update until stable; exactly one update with 4 B pulses.
- Assert i_reset mid A_HIGH -> o_swire=0, o_busy=0, o_done=0 same cycle (async). After release with start=1 -> full resend.
